// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for one inferred single-port RAM.
// After reset the RAM can optionally be swept to INIT_VALUE before any
// client access is granted.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | clear sweep: writes INIT_VALUE to init_addr each cycle
// ST_SERVE| normal operation: one granted client access per cycle
module ram_port_arbiter #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter bit                INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              hw_clk,
  input  logic              rst,
  output logic              ready,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_SERVE} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              last_b_q, last_b_d;      // 1: B holds the last grant
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d;
  logic [DATA_W-1:0] b_hold_q, b_hold_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;

  logic              a_gnt_c, b_gnt_c;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Round-robin grant: a lone request wins, on contention the port that
  // did not win last time goes. Nothing is granted while reset is asserted.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (ready_q && !rst) begin
      if (a_req && (!b_req || last_b_q)) begin
        a_gnt_c = 1'b1;
      end else if (b_req) begin
        b_gnt_c = 1'b1;
      end
    end
  end

  // Single RAM port steering: sweep owns the port during INIT, otherwise
  // the granted client does.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = init_addr_q;
    mem_wdata = INIT_VALUE;
    if (state_q == ST_INIT) begin
      mem_we = !rst;
    end else if (a_gnt_c) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt_c) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Sweep sequencing and registered ready.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (init_addr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_SERVE;
      end
    end
    ready_d = (state_d == ST_SERVE);
  end

  // Arbitration history, read-valid pulses and per-port read data hold.
  // The shared RAM output register is only meaningful in the rvalid cycle,
  // so each port latches it then to keep its rdata stable afterwards.
  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt_c) begin
      last_b_d = 1'b0;
    end else if (b_gnt_c) begin
      last_b_d = 1'b1;
    end
    a_rvalid_d = a_gnt_c && !a_we;
    b_rvalid_d = b_gnt_c && !b_we;
    a_hold_d   = a_rvalid_q ? ram_rdata_q : a_hold_q;
    b_hold_d   = b_rvalid_q ? ram_rdata_q : b_hold_q;
  end

  // Control registers with synchronous reset; the RAM itself is not reset.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q     <= INIT_CLEAR ? ST_INIT : ST_SERVE;
      ready_q     <= 1'b0;
      init_addr_q <= '0;
      last_b_q    <= 1'b1;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      init_addr_q <= init_addr_d;
      last_b_q    <= last_b_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
    end
  end

  // Inferred single-port RAM with registered read output.
  always_ff @(posedge hw_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    ram_rdata_q <= mem[mem_addr];
  end

  assign ready    = ready_q;
  assign a_gnt    = a_gnt_c;
  assign b_gnt    = b_gnt_c;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? ram_rdata_q : a_hold_q;
  assign b_rdata  = b_rvalid_q ? ram_rdata_q : b_hold_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences for
// reset/sweep corners, and constrained-random traffic against a model.
module tb_ram_port_arbiter;

  localparam int DEPTH = 256;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       hw_clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;

  ram_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .INIT_CLEAR(1'b1), .INIT_VALUE(8'h00)
  ) dut (
    .hw_clk(hw_clk), .rst(rst), .ready(ready),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 hw_clk = ~hw_clk;

  typedef struct {
    logic       rst;
    logic       a_req;
    logic       a_we;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       a_gnt;
    logic       b_gnt;
    logic       a_rv;
    logic [7:0] a_rd;
    logic       b_rv;
    logic [7:0] b_rd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles left until the sweep is done, a memory image,
  // who was served last, and what each port should be showing.
  int         init_left;
  logic       m_last_b;
  logic       m_arv, m_brv;
  logic [7:0] m_ard, m_brd;
  logic [7:0] m_mem [DEPTH];

  logic       obs_ready, obs_ag, obs_bg, obs_arv, obs_brv;
  logic [7:0] obs_ard, obs_brd;
  logic       e_ag, e_bg;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.a_req = 1'b0; s.a_we = 1'b0; s.a_addr = 8'h00; s.a_wdata = 8'h00;
    s.b_req = 1'b0; s.b_we = 1'b0; s.b_addr = 8'h00; s.b_wdata = 8'h00;
    return s;
  endfunction

  function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                              input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                              input logic xag, input logic xbg, input logic xarv, input logic [7:0] xard,
                              input logic xbrv, input logic [7:0] xbrd);
    vec_t v;
    v.s = idle();
    v.s.a_req = ar; v.s.a_we = aw; v.s.a_addr = aa; v.s.a_wdata = ad;
    v.s.b_req = br; v.s.b_we = bw; v.s.b_addr = ba; v.s.b_wdata = bd;
    v.a_gnt = xag; v.b_gnt = xbg; v.a_rv = xarv; v.a_rd = xard; v.b_rv = xbrv; v.b_rd = xbrd;
    return v;
  endfunction

  task automatic model_reset();
    init_left = DEPTH;
    m_last_b  = 1'b1;
    m_arv = 1'b0; m_brv = 1'b0;
    m_ard = 8'h00; m_brd = 8'h00;
  endtask

  // One clock: drive after the falling edge, compare outputs against the
  // model, then advance the model across the coming rising edge.
  task automatic do_cycle(input stim_t s);
    logic mready;
    @(negedge hw_clk);
    rst = s.rst;
    a_req = s.a_req; a_we = s.a_we; a_addr = s.a_addr; a_wdata = s.a_wdata;
    b_req = s.b_req; b_we = s.b_we; b_addr = s.b_addr; b_wdata = s.b_wdata;
    #1;
    obs_ready = ready; obs_ag = a_gnt; obs_bg = b_gnt;
    obs_arv = a_rvalid; obs_ard = a_rdata; obs_brv = b_rvalid; obs_brd = b_rdata;
    mready = (init_left == 0);
    e_ag = mready && !s.rst && s.a_req && (!s.b_req || m_last_b);
    e_bg = mready && !s.rst && s.b_req && !e_ag;
    chk("ready", obs_ready, mready);
    chk("a_gnt", obs_ag, e_ag);
    chk("b_gnt", obs_bg, e_bg);
    chk("a_rvalid", obs_arv, m_arv);
    chk("a_rdata", obs_ard, m_ard);
    chk("b_rvalid", obs_brv, m_brv);
    chk("b_rdata", obs_brd, m_brd);
    if (s.rst) begin
      model_reset();
    end else begin
      m_arv = 1'b0;
      m_brv = 1'b0;
      if (e_ag) begin
        m_last_b = 1'b0;
        if (s.a_we) m_mem[s.a_addr] = s.a_wdata;
        else begin m_arv = 1'b1; m_ard = m_mem[s.a_addr]; end
      end
      if (e_bg) begin
        m_last_b = 1'b1;
        if (s.b_we) m_mem[s.b_addr] = s.b_wdata;
        else begin m_brv = 1'b1; m_brd = m_mem[s.b_addr]; end
      end
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) begin
          for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    stim_t rs;
    int    rcount;
    int    gcount;
    logic  pa, pb;
    logic [7:0] raddr [5];

    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    model_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;

    // Directed table, starting on the first ready cycle after reset.
    tbl[0]  = mk(H,L,8'h10,8'h00, H,H,8'h10,8'h55, H,L, L,8'h00, L,8'h00);
    tbl[1]  = mk(H,L,8'h10,8'h00, H,H,8'h10,8'h55, L,H, H,8'h00, L,8'h00);
    tbl[2]  = mk(H,L,8'h10,8'h00, L,L,8'h00,8'h00, H,L, L,8'h00, L,8'h00);
    tbl[3]  = mk(L,L,8'h00,8'h00, L,L,8'h00,8'h00, L,L, H,8'h55, L,8'h00);
    tbl[4]  = mk(H,L,8'h00,8'h00, L,L,8'h00,8'h00, H,L, L,8'h55, L,8'h00);
    tbl[5]  = mk(H,L,8'h7F,8'h00, L,L,8'h00,8'h00, H,L, H,8'h00, L,8'h00);
    tbl[6]  = mk(H,L,8'hFF,8'h00, L,L,8'h00,8'h00, H,L, H,8'h00, L,8'h00);
    tbl[7]  = mk(H,H,8'h03,8'h0E, L,L,8'h00,8'h00, H,L, H,8'h00, L,8'h00);
    tbl[8]  = mk(H,L,8'h03,8'h00, L,L,8'h00,8'h00, H,L, L,8'h00, L,8'h00);
    tbl[9]  = mk(H,H,8'h03,8'h0F, L,L,8'h00,8'h00, H,L, H,8'h0E, L,8'h00);
    tbl[10] = mk(H,L,8'h03,8'h00, L,L,8'h00,8'h00, H,L, L,8'h0E, L,8'h00);
    tbl[11] = mk(L,L,8'h00,8'h00, L,L,8'h00,8'h00, L,L, H,8'h0F, L,8'h00);
    tbl[12] = mk(L,L,8'h00,8'h00, H,L,8'h10,8'h00, L,H, L,8'h0F, L,8'h00);
    tbl[13] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, H,L, L,8'h0F, H,8'h55);
    tbl[14] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, L,H, H,8'h55, L,8'h55);
    tbl[15] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, H,L, L,8'h55, H,8'h0F);
    tbl[16] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, L,H, H,8'h55, L,8'h0F);
    tbl[17] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, H,L, L,8'h55, H,8'h0F);
    tbl[18] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, L,H, H,8'h55, L,8'h0F);
    tbl[19] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, H,L, L,8'h55, H,8'h0F);
    tbl[20] = mk(H,L,8'h10,8'h00, H,L,8'h03,8'h00, L,H, H,8'h55, L,8'h0F);
    tbl[21] = mk(L,L,8'h00,8'h00, L,L,8'h00,8'h00, L,L, L,8'h55, H,8'h0F);
    tbl[22] = mk(L,L,8'h00,8'h00, L,L,8'h00,8'h00, L,L, L,8'h55, L,8'h0F);

    // Reset for two cycles; reset-state outputs checked by the model.
    s = idle(); s.rst = 1'b1;
    do_cycle(s);
    do_cycle(s);

    // Sweep with both ports requesting from reset release: no grants,
    // ready low for the 256 cycles after release.
    s = tbl[0].s;
    rcount = 0; gcount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(s);
      if (obs_ready) rcount++;
      if (obs_ag || obs_bg) gcount++;
    end
    chk("ready during sweep", rcount, 0);
    chk("grants during sweep", gcount, 0);

    for (int i = 0; i < 23; i++) begin
      do_cycle(tbl[i].s);
      if (i == 0) chk("ready after 256 edges", obs_ready, 1'b1);
      chk($sformatf("tbl%0d a_gnt", i), obs_ag, tbl[i].a_gnt);
      chk($sformatf("tbl%0d b_gnt", i), obs_bg, tbl[i].b_gnt);
      chk($sformatf("tbl%0d a_rvalid", i), obs_arv, tbl[i].a_rv);
      chk($sformatf("tbl%0d a_rdata", i), obs_ard, tbl[i].a_rd);
      chk($sformatf("tbl%0d b_rvalid", i), obs_brv, tbl[i].b_rv);
      chk($sformatf("tbl%0d b_rdata", i), obs_brd, tbl[i].b_rd);
    end

    // Reset mid-SERVE with a read result showing, then reset mid-sweep.
    s = idle(); s.a_req = 1'b1; s.a_addr = 8'h10;
    do_cycle(s);
    chk("pre-reset a_gnt", obs_ag, 1'b1);
    s = idle(); s.rst = 1'b1;
    do_cycle(s);
    chk("pre-reset a_rvalid", obs_arv, 1'b1);
    chk("pre-reset a_rdata", obs_ard, 8'h55);
    do_cycle(idle());
    chk("post-reset a_rvalid", obs_arv, 1'b0);
    chk("post-reset a_rdata", obs_ard, 8'h00);
    rcount = 0;
    for (int i = 1; i < 100; i++) begin
      do_cycle(idle());
      if (obs_ready) rcount++;
    end
    s = idle(); s.rst = 1'b1;
    do_cycle(s);
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(idle());
      if (obs_ready) rcount++;
    end
    chk("ready low across restarted sweep", rcount, 0);

    raddr[0] = 8'h00; raddr[1] = 8'h10; raddr[2] = 8'h65; raddr[3] = 8'hC8; raddr[4] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.a_req = 1'b1; s.a_addr = raddr[i];
      do_cycle(s);
      if (i == 0) chk("ready after restarted sweep", obs_ready, 1'b1);
      chk($sformatf("clr rd %0h a_gnt", raddr[i]), obs_ag, 1'b1);
      do_cycle(idle());
      chk($sformatf("clr rd %0h a_rvalid", raddr[i]), obs_arv, 1'b1);
      chk($sformatf("clr rd %0h a_rdata", raddr[i]), obs_ard, 8'h00);
    end
    s = idle(); s.b_req = 1'b1; s.b_addr = 8'h03;
    do_cycle(s);
    chk("clr rd 03 b_gnt", obs_bg, 1'b1);
    do_cycle(idle());
    chk("clr rd 03 b_rvalid", obs_brv, 1'b1);
    chk("clr rd 03 b_rdata", obs_brd, 8'h00);

    // Random traffic obeying the hold-until-granted protocol.
    rs = idle();
    pa = 1'b0; pb = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pa) begin
        if ($urandom_range(0, 9) < 6) begin
          pa = 1'b1;
          rs.a_we    = 1'($urandom_range(0, 1));
          rs.a_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
          rs.a_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        pa = 1'b0;
      end
      if (!pb) begin
        if ($urandom_range(0, 9) < 6) begin
          pb = 1'b1;
          rs.b_we    = 1'($urandom_range(0, 1));
          rs.b_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
          rs.b_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        pb = 1'b0;
      end
      rs.a_req = pa;
      rs.b_req = pb;
      do_cycle(rs);
      if (e_ag) pa = 1'b0;
      if (e_bg) pb = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
